// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the tile configuration loader: FSM encoding and CRC-8 constants.
package kfpga_config_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int                   CRC_WIDTH = 8;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY  = 8'h07;
  localparam logic [CRC_WIDTH-1:0] CRC_INIT  = 8'h00;

  // One MSB-first step of the CRC-8 LFSR.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic                 bit_in);
    logic feedback;
    feedback = crc[CRC_WIDTH-1] ^ bit_in;
    crc_step = {crc[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/config_crc8_serial.sv
// Bit-serial CRC-8 accumulator over the configuration data bits (used when CONFIG_CRC_EN is defined).
module config_crc8_serial
  import kfpga_config_pkg::*;
(
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 clear,
  input  logic                 bit_en,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc_out
);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      crc_out <= CRC_INIT;
    end else if (clear) begin
      crc_out <= CRC_INIT;
    end else if (bit_en) begin
      crc_out <= crc_step(crc_out, bit_in);
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Serial, double-buffered configuration loader for routing-mux selectors with daisy-chain output.
// Optional CRC-8 trailer check is enabled by defining CONFIG_CRC_EN.
module config_chain_loader
  import kfpga_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = 12
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    load_start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_data,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    chain_out,
  output logic                    busy,
  output logic                    error
);

  localparam int CNT_W = $clog2(CONFIG_WIDTH + 1);

  state_t                  state, next_state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic                    start_load, shift_en, last_data;

  assign start_load = (state == IDLE) && load_start;
  assign shift_en   = (state == SHIFT) && cfg_valid;
  assign last_data  = (bit_cnt == CNT_W'(CONFIG_WIDTH - 1));
  assign busy       = (state != IDLE);

`ifdef CONFIG_CRC_EN
  localparam int CRC_CNT_W = $clog2(CRC_WIDTH);

  logic [CRC_WIDTH-1:0] crc_calc, crc_cmp;
  logic [CRC_CNT_W-1:0] crc_cnt;
  logic                 check_en, check_done, crc_match;

  assign check_en   = (state == CHECK) && cfg_valid;
  assign check_done = check_en && (crc_cnt == CRC_CNT_W'(CRC_WIDTH - 1));
  // The final trailer bit is compared as it arrives, without waiting for it to land in crc_cmp.
  assign crc_match  = ({crc_cmp[CRC_WIDTH-2:0], cfg_data} == crc_calc);

  config_crc8_serial u_crc (
    .clock   (clock),
    .nreset  (nreset),
    .clear   (start_load),
    .bit_en  (shift_en),
    .bit_in  (cfg_data),
    .crc_out (crc_calc)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      crc_cmp <= '0;
      crc_cnt <= '0;
      error   <= 1'b0;
    end else begin
      if (start_load) begin
        crc_cnt <= '0;
        error   <= 1'b0;
      end
      if (check_en) begin
        crc_cmp <= {crc_cmp[CRC_WIDTH-2:0], cfg_data};
        crc_cnt <= crc_cnt + CRC_CNT_W'(1);
      end
      if (check_done && !crc_match) error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned and infers a latch.
    next_state = state;
    cfg_ready  = 1'b0;
    case (state)
      IDLE:   if (load_start) next_state = SHIFT;
      SHIFT: begin
        cfg_ready = 1'b1;
`ifdef CONFIG_CRC_EN
        if (cfg_valid && last_data) next_state = CHECK;
`else
        if (cfg_valid && last_data) next_state = COMMIT;
`endif
      end
`ifdef CONFIG_CRC_EN
      CHECK: begin
        cfg_ready = 1'b1;
        if (check_done) next_state = crc_match ? COMMIT : IDLE;
      end
`endif
      COMMIT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shadow keeps its contents across load_start, so the previous configuration streams out to the
  // next tile while the new one streams in.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      // NOTE: shadow is a flop register, not a RAM, so it is reset; chain_out must not leak stale bits.
      shadow       <= '0;
      bit_cnt      <= '0;
      chain_out    <= 1'b0;
      config_out   <= '0;
      config_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so chain_out captures the MSB from before this edge's shift.
      if (start_load) bit_cnt <= '0;
      if (shift_en) begin
        shadow    <= {shadow[CONFIG_WIDTH-2:0], cfg_data};
        chain_out <= shadow[CONFIG_WIDTH-1];
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      if (state == COMMIT) begin
        config_out   <= shadow;
        config_valid <= 1'b1;
      end
    end
  end

endmodule
